fx_arb2: RTL

Two-master arbiter for the fx register bus. It lets the UART command master (commu_top) and the SPI1 slave-port master share the single fx slave bus that feeds control_top. Each master holds a write or read request until it receives a one-cycle acknowledge. The arbiter serialises the requests with round-robin fairness, drives single-cycle fx_wr/fx_rd strobes, and returns registered read data.

---
 rtl/fx_pkg.sv | 20 ++
 rtl/fx_rr_pick.sv | 22 ++
 rtl/fx_arb2.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fx_pkg.sv
// Shared widths and types for the two-master fx register bus arbiter.
package fx_pkg;

  localparam int unsigned FX_AW = 22;
  localparam int unsigned FX_DW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRwait,
    StAck
  } fx_state_e;

  typedef enum logic {
    MstU,
    MstS
  } fx_mst_e;

endpackage

// File: rtl/fx_rr_pick.sv
// Two-way round-robin pick: on contention the master not granted last wins.
module fx_rr_pick
  import fx_pkg::*;
(
  input  logic    pend_u,
  input  logic    pend_s,
  input  fx_mst_e last_grant,
  output logic    gnt_valid,
  output fx_mst_e gnt_id
);

  always_comb begin
    gnt_valid = pend_u | pend_s;
    gnt_id    = MstU;
    if (pend_u && pend_s) begin
      gnt_id = (last_grant == MstS) ? MstU : MstS;
    end else if (pend_s) begin
      gnt_id = MstS;
    end
  end

endmodule

// File: rtl/fx_arb2.sv
// Serialises UART and SPI master requests onto the fx slave bus with registered
// strobes, acks and read data.
module fx_arb2
  import fx_pkg::*;
#(
  parameter int unsigned AW     = FX_AW,
  parameter int unsigned DW     = FX_DW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          mu_wr,
  input  logic [AW-1:0] mu_waddr,
  input  logic [DW-1:0] mu_data,
  input  logic          mu_rd,
  input  logic [AW-1:0] mu_raddr,
  output logic          mu_ack,
  output logic [DW-1:0] mu_q,
  input  logic          ms_wr,
  input  logic [AW-1:0] ms_waddr,
  input  logic [DW-1:0] ms_data,
  input  logic          ms_rd,
  input  logic [AW-1:0] ms_raddr,
  output logic          ms_ack,
  output logic [DW-1:0] ms_q,
  output logic          fx_wr,
  output logic [AW-1:0] fx_waddr,
  output logic [DW-1:0] fx_data,
  output logic          fx_rd,
  output logic [AW-1:0] fx_raddr,
  input  logic [DW-1:0] fx_q
);

  localparam int unsigned CntW = 3;

  fx_state_e       state_q, state_d;
  fx_mst_e         last_grant_q, last_grant_d;
  fx_mst_e         gnt_id_q, gnt_id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fx_wr_q, fx_wr_d, fx_rd_q, fx_rd_d;
  logic            mu_ack_q, mu_ack_d, ms_ack_q, ms_ack_d;
  logic [AW-1:0]   fx_waddr_q, fx_waddr_d, fx_raddr_q, fx_raddr_d;
  logic [DW-1:0]   fx_data_q, fx_data_d, mu_q_q, mu_q_d, ms_q_q, ms_q_d;

  logic    pend_u, pend_s, pick_valid, pick_wr;
  fx_mst_e pick_id;

  assign pend_u = mu_wr | mu_rd;
  assign pend_s = ms_wr | ms_rd;

  fx_rr_pick u_rr_pick (
    .pend_u     (pend_u),
    .pend_s     (pend_s),
    .last_grant (last_grant_q),
    .gnt_valid  (pick_valid),
    .gnt_id     (pick_id)
  );

  // A master's write wins over its own read; the read waits for a later grant.
  assign pick_wr = (pick_id == MstU) ? mu_wr : ms_wr;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_valid) state_d = pick_wr ? StWr : StRd;
      StWr:    state_d = StIdle;
      StRd:    state_d = StRwait;
      StRwait: if (cnt_q == '0) state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fx_wr_d      = 1'b0;
    fx_rd_d      = 1'b0;
    mu_ack_d     = 1'b0;
    ms_ack_d     = 1'b0;
    fx_waddr_d   = fx_waddr_q;
    fx_data_d    = fx_data_q;
    fx_raddr_d   = fx_raddr_q;
    mu_q_d       = mu_q_q;
    ms_q_d       = ms_q_q;
    cnt_d        = cnt_q;
    gnt_id_d     = gnt_id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_id_d     = pick_id;
          last_grant_d = pick_id;
          if (pick_wr) begin
            fx_wr_d    = 1'b1;
            fx_waddr_d = (pick_id == MstU) ? mu_waddr : ms_waddr;
            fx_data_d  = (pick_id == MstU) ? mu_data : ms_data;
            if (pick_id == MstU) mu_ack_d = 1'b1;
            else                 ms_ack_d = 1'b1;
          end else begin
            fx_rd_d    = 1'b1;
            fx_raddr_d = (pick_id == MstU) ? mu_raddr : ms_raddr;
          end
        end
      end
      StRd: cnt_d = CntW'(RD_LAT - 1);
      StRwait: begin
        if (cnt_q == '0) begin
          if (gnt_id_q == MstU) begin
            mu_q_d   = fx_q;
            mu_ack_d = 1'b1;
          end else begin
            ms_q_d   = fx_q;
            ms_ack_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      last_grant_q <= MstS;
      gnt_id_q     <= MstU;
      cnt_q        <= '0;
      fx_wr_q      <= 1'b0;
      fx_rd_q      <= 1'b0;
      mu_ack_q     <= 1'b0;
      ms_ack_q     <= 1'b0;
      fx_waddr_q   <= '0;
      fx_data_q    <= '0;
      fx_raddr_q   <= '0;
      mu_q_q       <= '0;
      ms_q_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      cnt_q        <= cnt_d;
      fx_wr_q      <= fx_wr_d;
      fx_rd_q      <= fx_rd_d;
      mu_ack_q     <= mu_ack_d;
      ms_ack_q     <= ms_ack_d;
      fx_waddr_q   <= fx_waddr_d;
      fx_data_q    <= fx_data_d;
      fx_raddr_q   <= fx_raddr_d;
      mu_q_q       <= mu_q_d;
      ms_q_q       <= ms_q_d;
    end
  end

  assign fx_wr    = fx_wr_q;
  assign fx_rd    = fx_rd_q;
  assign fx_waddr = fx_waddr_q;
  assign fx_data  = fx_data_q;
  assign fx_raddr = fx_raddr_q;
  assign mu_ack   = mu_ack_q;
  assign ms_ack   = ms_ack_q;
  assign mu_q     = mu_q_q;
  assign ms_q     = ms_q_q;

endmodule
